// File: rtl/serial_frame_weight_checker.sv
// Frames a gated serial bit stream into FRAME_LEN-bit frames, counts ones per frame,
// and reports a mode-selected weight verdict plus saturating frame/match statistics.
module serial_frame_weight_checker #(
  parameter int FRAME_LEN   = 5,
  parameter int ONES_TARGET = 3,
  parameter int ALIGN       = 1,
  parameter int STAT_W      = 16,
  localparam int CW         = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              resetH,
  input  logic              din,
  input  logic              din_vld,
  input  logic              sof,
  input  logic [1:0]        mode,
  output logic              frame_done,
  output logic              valid,
  output logic [CW-1:0]     ones_cnt,
  output logic              abort,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] match_cnt
);

  localparam int IW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0]     IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0]     LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]     ACC_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]     ONES_TGT = CW'(ONES_TARGET);
  localparam logic [CW-1:0]     ZERO_TGT = CW'(FRAME_LEN - ONES_TARGET);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam state_t ST_INIT = (ALIGN != 0) ? ST_HUNT : ST_COLLECT;

  state_t        state_r;
  logic [IW-1:0] bit_idx_r;
  logic [CW-1:0] acc_r;
  logic [1:0]    mode_q_r;

  logic [IW-1:0] idx_s;
  logic [CW-1:0] acc_base_s;
  logic [CW-1:0] acc_final_s;
  logic [1:0]    mode_s;
  logic          last_s;
  logic          verdict_s;

  // Effective position, running count and mode for the bit being sampled; sof restarts the frame.
  always_comb begin
    idx_s      = bit_idx_r;
    acc_base_s = acc_r;
    mode_s     = mode_q_r;
    if (sof) begin
      idx_s      = IDX_ZERO;
      acc_base_s = ACC_ZERO;
      mode_s     = mode;
    end else if (bit_idx_r == IDX_ZERO) begin
      idx_s      = IDX_ZERO;
      acc_base_s = acc_r;
      mode_s     = mode;
    end else begin
      idx_s      = bit_idx_r;
      acc_base_s = acc_r;
      mode_s     = mode_q_r;
    end
    acc_final_s = acc_base_s + CW'(din);
    last_s      = (idx_s == LAST_IDX);
    case (mode_s)
      2'b00:   verdict_s = (acc_final_s == ONES_TGT);
      2'b01:   verdict_s = (acc_final_s >= ONES_TGT);
      2'b10:   verdict_s = (acc_final_s <= ONES_TGT);
      2'b11:   verdict_s = (acc_final_s == ZERO_TGT);
      default: verdict_s = 1'b0;
    endcase
  end

  // Framing FSM, accumulator and all registered outputs.
  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state_r    <= ST_INIT;
      bit_idx_r  <= IDX_ZERO;
      acc_r      <= ACC_ZERO;
      mode_q_r   <= 2'b00;
      frame_done <= 1'b0;
      valid      <= 1'b0;
      ones_cnt   <= ACC_ZERO;
      abort      <= 1'b0;
      frame_cnt  <= {STAT_W{1'b0}};
      match_cnt  <= {STAT_W{1'b0}};
    end else begin
      frame_done <= 1'b0;
      abort      <= 1'b0;
      if (din_vld) begin
        case (state_r)
          ST_HUNT: begin
            if (sof) begin
              state_r   <= ST_COLLECT;
              bit_idx_r <= IW'(1);
              acc_r     <= acc_final_s;
              mode_q_r  <= mode_s;
            end else begin
              state_r   <= ST_HUNT;
            end
          end
          ST_COLLECT: begin
            // A sof landing mid-frame throws away the partial frame without touching statistics.
            abort    <= sof && (bit_idx_r != IDX_ZERO);
            mode_q_r <= mode_s;
            if (last_s) begin
              bit_idx_r  <= IDX_ZERO;
              acc_r      <= ACC_ZERO;
              frame_done <= 1'b1;
              valid      <= verdict_s;
              ones_cnt   <= acc_final_s;
              if (frame_cnt != STAT_MAX) begin
                frame_cnt <= frame_cnt + STAT_W'(1);
              end else begin
                frame_cnt <= frame_cnt;
              end
              if (verdict_s && (match_cnt != STAT_MAX)) begin
                match_cnt <= match_cnt + STAT_W'(1);
              end else begin
                match_cnt <= match_cnt;
              end
            end else begin
              bit_idx_r <= idx_s + IW'(1);
              acc_r     <= acc_final_s;
            end
          end
          default: begin
            state_r   <= ST_INIT;
            bit_idx_r <= IDX_ZERO;
            acc_r     <= ACC_ZERO;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_weight_checker.sv
// Randomized self-checking bench: aligned (default), free-running and narrow-statistics instances
// share one stimulus stream and are compared against a frame-level reference model.
module tb_serial_frame_weight_checker;

  localparam int FL  = 5;
  localparam int TGT = 3;
  localparam int CW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetH, din, din_vld, sof;
  logic [1:0] mode;

  logic          fd_a, v_a, ab_a;
  logic [CW-1:0] on_a;
  logic [15:0]   fc_a, mc_a;
  logic          fd_f, v_f, ab_f;
  logic [CW-1:0] on_f;
  logic [15:0]   fc_f, mc_f;
  logic          fd_s, v_s, ab_s;
  logic [CW-1:0] on_s;
  logic [1:0]    fc_s, mc_s;

  serial_frame_weight_checker #(.FRAME_LEN(FL), .ONES_TARGET(TGT), .ALIGN(1), .STAT_W(16)) dut_a (
    .clk(clk), .resetH(resetH), .din(din), .din_vld(din_vld), .sof(sof), .mode(mode),
    .frame_done(fd_a), .valid(v_a), .ones_cnt(on_a), .abort(ab_a), .frame_cnt(fc_a), .match_cnt(mc_a));

  serial_frame_weight_checker #(.FRAME_LEN(FL), .ONES_TARGET(TGT), .ALIGN(0), .STAT_W(16)) dut_f (
    .clk(clk), .resetH(resetH), .din(din), .din_vld(din_vld), .sof(sof), .mode(mode),
    .frame_done(fd_f), .valid(v_f), .ones_cnt(on_f), .abort(ab_f), .frame_cnt(fc_f), .match_cnt(mc_f));

  serial_frame_weight_checker #(.FRAME_LEN(FL), .ONES_TARGET(TGT), .ALIGN(1), .STAT_W(2)) dut_s (
    .clk(clk), .resetH(resetH), .din(din), .din_vld(din_vld), .sof(sof), .mode(mode),
    .frame_done(fd_s), .valid(v_s), .ones_cnt(on_s), .abort(ab_s), .frame_cnt(fc_s), .match_cnt(mc_s));

  int checks = 0;
  int errors = 0;

  // reference model state
  int   exp_frames, exp_matches, exp_ones;
  logic exp_valid;

  // observations captured while a frame is driven
  logic          obs_done, obs_valid, obs_first_abort, obs_f_done;
  logic [CW-1:0] obs_ones;
  logic [15:0]   obs_fcnt, obs_mcnt;
  logic [1:0]    obs_s_fcnt, obs_s_mcnt;
  int            obs_extra, obs_f_extra;

  function automatic int ref_ones(input logic [31:0] pat);
    int n = 0;
    for (int i = 0; i < FL; i++) n += (pat[i] ? 1 : 0);
    return n;
  endfunction

  function automatic logic ref_verdict(input int ones, input logic [1:0] m);
    case (m)
      2'd0:    return (ones == TGT);
      2'd1:    return (ones >= TGT);
      2'd2:    return (ones <= TGT);
      default: return ((FL - ones) == TGT);
    endcase
  endfunction

  task automatic model_frame(input logic [31:0] pat, input logic [1:0] m0);
    exp_ones    = ref_ones(pat);
    exp_valid   = ref_verdict(exp_ones, m0);
    exp_frames  = exp_frames + 1;
    exp_matches = exp_matches + (exp_valid ? 1 : 0);
  endtask

  task automatic apply_reset();
    resetH = 1'b1; din = 1'b0; din_vld = 1'b0; sof = 1'b0; mode = 2'b00;
    repeat (2) @(posedge clk);
    #1 resetH = 1'b0;
    exp_frames = 0; exp_matches = 0;
  endtask

  // Drives nb qualified bits (pat[0] first) with gap idle cycles between them and records outputs.
  task automatic send_frame(input int nb, input logic [31:0] pat, input logic [1:0] m0,
                            input logic [1:0] mm, input bit with_sof, input int gap);
    obs_extra = 0; obs_f_extra = 0; obs_first_abort = 1'b0; obs_done = 1'b0; obs_f_done = 1'b0;
    for (int i = 0; i < nb; i++) begin
      din = pat[i]; sof = (i == 0) && with_sof; mode = (i == 0) ? m0 : mm; din_vld = 1'b1;
      @(posedge clk); #1;
      din_vld = 1'b0; sof = 1'b0;
      if (i == 0) obs_first_abort = ab_a;
      else if (ab_a) obs_extra++;
      if (i == nb - 1) begin
        obs_done = fd_a; obs_f_done = fd_f; obs_valid = v_a; obs_ones = on_a;
        obs_fcnt = fc_a; obs_mcnt = mc_a; obs_s_fcnt = fc_s; obs_s_mcnt = mc_s;
      end else begin
        if (fd_a) obs_extra++;
        if (fd_f) obs_f_extra++;
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          if (fd_a || ab_a) obs_extra++;
          if (fd_f) obs_f_extra++;
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (fd_a !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b exp 0", fd_a); end
    checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", v_a); end
    checks++; if (on_a !== 3'd0) begin errors++; $display("FAIL reset_ones got %0d exp 0", on_a); end
    checks++; if (ab_a !== 1'b0) begin errors++; $display("FAIL reset_abort got %0b exp 0", ab_a); end
    checks++; if (fc_a !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", fc_a); end
    checks++; if (mc_a !== 16'd0) begin errors++; $display("FAIL reset_match_cnt got %0d exp 0", mc_a); end
  endtask

  task automatic test_basic();
    logic [31:0] pats [2];
    pats[0] = 32'b01011; pats[1] = 32'b01111;
    for (int k = 0; k < 2; k++) begin
      send_frame(FL, pats[k], 2'b00, 2'b00, (k == 0), 0);
      model_frame(pats[k], 2'b00);
      checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL basic_done f%0d got %0b exp 1", k, obs_done); end
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL basic_valid f%0d got %0b exp %0b", k, obs_valid, exp_valid); end
      checks++; if (obs_ones !== CW'(exp_ones)) begin errors++; $display("FAIL basic_ones f%0d got %0d exp %0d", k, obs_ones, exp_ones); end
      checks++; if (obs_fcnt !== 16'(exp_frames)) begin errors++; $display("FAIL basic_frame_cnt f%0d got %0d exp %0d", k, obs_fcnt, exp_frames); end
      checks++; if (obs_mcnt !== 16'(exp_matches)) begin errors++; $display("FAIL basic_match_cnt f%0d got %0d exp %0d", k, obs_mcnt, exp_matches); end
      checks++; if (obs_extra !== 0) begin errors++; $display("FAIL basic_stray_pulses f%0d got %0d exp 0", k, obs_extra); end
    end
  endtask

  task automatic test_gaps();
    send_frame(FL, 32'b01011, 2'b00, 2'b00, 1'b0, 3);
    model_frame(32'b01011, 2'b00);
    checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL gaps_done got %0b exp 1", obs_done); end
    checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL gaps_valid got %0b exp %0b", obs_valid, exp_valid); end
    checks++; if (obs_ones !== CW'(exp_ones)) begin errors++; $display("FAIL gaps_ones got %0d exp %0d", obs_ones, exp_ones); end
    checks++; if (obs_extra !== 0) begin errors++; $display("FAIL gaps_stray_pulses got %0d exp 0", obs_extra); end
    @(posedge clk); #1;
    checks++; if (fd_a !== 1'b0) begin errors++; $display("FAIL gaps_pulse_width got %0b exp 0", fd_a); end
    checks++; if (v_a !== exp_valid) begin errors++; $display("FAIL gaps_valid_hold got %0b exp %0b", v_a, exp_valid); end
  endtask

  task automatic test_modes();
    logic [31:0] pats [4];
    logic [1:0]  m0s [4];
    logic [1:0]  mms [4];
    pats[0] = 32'b01111; m0s[0] = 2'b01; mms[0] = 2'b01;
    pats[1] = 32'b01111; m0s[1] = 2'b10; mms[1] = 2'b10;
    pats[2] = 32'b01100; m0s[2] = 2'b11; mms[2] = 2'b11;
    pats[3] = 32'b01111; m0s[3] = 2'b00; mms[3] = 2'b01;
    for (int k = 0; k < 4; k++) begin
      send_frame(FL, pats[k], m0s[k], mms[k], 1'b1, 0);
      model_frame(pats[k], m0s[k]);
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL mode_valid case%0d got %0b exp %0b", k, obs_valid, exp_valid); end
      checks++; if (obs_mcnt !== 16'(exp_matches)) begin errors++; $display("FAIL mode_match_cnt case%0d got %0d exp %0d", k, obs_mcnt, exp_matches); end
    end
  endtask

  task automatic test_align();
    apply_reset();
    send_frame(FL, $urandom, 2'b00, 2'b00, 1'b0, 0);
    checks++; if (obs_done !== 1'b0) begin errors++; $display("FAIL align_hunt_done got %0b exp 0", obs_done); end
    checks++; if (obs_extra !== 0) begin errors++; $display("FAIL align_hunt_pulses got %0d exp 0", obs_extra); end
    checks++; if (obs_fcnt !== 16'd0) begin errors++; $display("FAIL align_hunt_frame_cnt got %0d exp 0", obs_fcnt); end
    checks++; if (obs_f_done !== 1'b1) begin errors++; $display("FAIL align_free_done got %0b exp 1", obs_f_done); end
    send_frame(2, 32'b11, 2'b00, 2'b00, 1'b1, 0);
    checks++; if (obs_first_abort !== 1'b0) begin errors++; $display("FAIL align_start_abort got %0b exp 0", obs_first_abort); end
    send_frame(FL, 32'b01011, 2'b00, 2'b00, 1'b1, 0);
    model_frame(32'b01011, 2'b00);
    checks++; if (obs_first_abort !== 1'b1) begin errors++; $display("FAIL align_abort got %0b exp 1", obs_first_abort); end
    checks++; if (obs_extra !== 0) begin errors++; $display("FAIL align_abort_pulses got %0d exp 0", obs_extra); end
    checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL align_done got %0b exp 1", obs_done); end
    checks++; if (obs_ones !== CW'(exp_ones)) begin errors++; $display("FAIL align_ones got %0d exp %0d", obs_ones, exp_ones); end
    checks++; if (obs_fcnt !== 16'(exp_frames)) begin errors++; $display("FAIL align_frame_cnt got %0d exp %0d", obs_fcnt, exp_frames); end
  endtask

  task automatic test_reset_mid();
    send_frame(3, 32'b111, 2'b00, 2'b00, 1'b1, 0);
    #2 resetH = 1'b1;
    #1;
    checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b exp 0", v_a); end
    checks++; if (on_a !== 3'd0) begin errors++; $display("FAIL rstmid_ones got %0d exp 0", on_a); end
    checks++; if (fc_a !== 16'd0) begin errors++; $display("FAIL rstmid_frame_cnt got %0d exp 0", fc_a); end
    checks++; if (mc_a !== 16'd0) begin errors++; $display("FAIL rstmid_match_cnt got %0d exp 0", mc_a); end
    @(posedge clk); #1 resetH = 1'b0;
    exp_frames = 0; exp_matches = 0;
    send_frame(FL, 32'b01011, 2'b00, 2'b00, 1'b0, 0);
    checks++; if (obs_done !== 1'b0) begin errors++; $display("FAIL rstmid_hunt_done got %0b exp 0", obs_done); end
    checks++; if (obs_f_extra !== 0) begin errors++; $display("FAIL rstmid_free_early got %0d exp 0", obs_f_extra); end
    checks++; if (obs_f_done !== 1'b1) begin errors++; $display("FAIL rstmid_free_done got %0b exp 1", obs_f_done); end
    send_frame(FL, 32'b01011, 2'b00, 2'b00, 1'b1, 0);
    model_frame(32'b01011, 2'b00);
    checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL rstmid_done got %0b exp 1", obs_done); end
    checks++; if (obs_fcnt !== 16'(exp_frames)) begin errors++; $display("FAIL rstmid_frame_cnt2 got %0d exp %0d", obs_fcnt, exp_frames); end
  endtask

  task automatic test_random();
    bit          prev_partial = 1'b0;
    logic [31:0] pat;
    logic [1:0]  m0, mm;
    int          gap;
    for (int k = 0; k < 40; k++) begin
      pat = $urandom; m0 = 2'($urandom_range(0, 3)); mm = 2'($urandom_range(0, 3));
      gap = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) begin
        send_frame($urandom_range(1, FL - 1), pat, m0, mm, 1'b1, gap);
        checks++; if (obs_first_abort !== prev_partial) begin errors++; $display("FAIL rand_partial_abort it%0d got %0b exp %0b", k, obs_first_abort, prev_partial); end
        checks++; if ((obs_done !== 1'b0) || (obs_extra !== 0)) begin errors++; $display("FAIL rand_partial_pulses it%0d done %0b extra %0d exp 0/0", k, obs_done, obs_extra); end
        prev_partial = 1'b1;
      end else begin
        send_frame(FL, pat, m0, mm, prev_partial || ($urandom_range(0, 1) == 1), gap);
        model_frame(pat, m0);
        checks++; if (obs_first_abort !== prev_partial) begin errors++; $display("FAIL rand_abort it%0d got %0b exp %0b", k, obs_first_abort, prev_partial); end
        checks++; if ((obs_done !== 1'b1) || (obs_extra !== 0)) begin errors++; $display("FAIL rand_pulses it%0d done %0b extra %0d exp 1/0", k, obs_done, obs_extra); end
        checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL rand_valid it%0d got %0b exp %0b", k, obs_valid, exp_valid); end
        checks++; if (obs_ones !== CW'(exp_ones)) begin errors++; $display("FAIL rand_ones it%0d got %0d exp %0d", k, obs_ones, exp_ones); end
        checks++; if (obs_fcnt !== 16'(exp_frames)) begin errors++; $display("FAIL rand_frame_cnt it%0d got %0d exp %0d", k, obs_fcnt, exp_frames); end
        checks++; if (obs_mcnt !== 16'(exp_matches)) begin errors++; $display("FAIL rand_match_cnt it%0d got %0d exp %0d", k, obs_mcnt, exp_matches); end
        prev_partial = 1'b0;
      end
    end
  endtask

  task automatic test_saturation();
    int sat;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      send_frame(FL, 32'b01011, 2'b00, 2'b00, (k == 0), 0);
      model_frame(32'b01011, 2'b00);
      sat = (exp_frames > 3) ? 3 : exp_frames;
      checks++; if (obs_s_fcnt !== 2'(sat)) begin errors++; $display("FAIL sat_frame_cnt f%0d got %0d exp %0d", k, obs_s_fcnt, sat); end
      sat = (exp_matches > 3) ? 3 : exp_matches;
      checks++; if (obs_s_mcnt !== 2'(sat)) begin errors++; $display("FAIL sat_match_cnt f%0d got %0d exp %0d", k, obs_s_mcnt, sat); end
      checks++; if (obs_fcnt !== 16'(exp_frames)) begin errors++; $display("FAIL sat_wide_frame_cnt f%0d got %0d exp %0d", k, obs_fcnt, exp_frames); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_modes();
    test_align();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
